// File: rtl/stack_alu_param.sv
// Parametrised signed stack ALU with PUSH/POP/DUP/SWAP/ADD/SUB and an
// iterative shift-add multiplier behind a ready/op_done handshake.
module stack_alu_param #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] input_data,
    input  logic        [2:0]       opcode,
    output logic                    ready,
    output logic                    op_done,
    output logic signed [WIDTH-1:0] output_data,
    output logic                    overflow,
    output logic                    invalid,
    output logic        [CW-1:0]    count,
    output logic                    empty,
    output logic                    full
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CYW = $clog2(WIDTH + 1);
    localparam int PW  = 2 * WIDTH;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SWAP = 3'b010;
    localparam logic [2:0] OP_DUP  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             inv_q, inv_d;
    logic             done_q, done_d;
    logic [0:0]       state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [CYW-1:0]   cyc_q, cyc_d;

    logic [AW-1:0]    tidx, nidx, pidx;
    logic [WIDTH-1:0] t_val, n_val, mag_t, mag_n;
    logic             has1, has2, room;
    logic [WIDTH:0]   sum, dif;
    logic [PW-1:0]    acc_nxt, prod;

    assign tidx  = AW'(count_q - CW'(1));
    assign nidx  = AW'(count_q - CW'(2));
    assign pidx  = AW'(count_q);
    assign t_val = stack_q[tidx];
    assign n_val = stack_q[nidx];
    assign mag_t = t_val[WIDTH-1] ? -t_val : t_val;
    assign mag_n = n_val[WIDTH-1] ? -n_val : n_val;
    assign has1  = count_q >= CW'(1);
    assign has2  = count_q >= CW'(2);
    assign room  = count_q < CW'(DEPTH);

    // One extra sign bit exposes signed overflow as s[W] != s[W-1].
    assign sum = {n_val[WIDTH-1], n_val} + {t_val[WIDTH-1], t_val};
    assign dif = {n_val[WIDTH-1], n_val} - {t_val[WIDTH-1], t_val};

    assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod    = neg_q ? -acc_nxt : acc_nxt;

    always_comb begin
        stack_d  = stack_q;
        count_d  = count_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;
        done_d   = 1'b0;
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cyc_d    = cyc_q;
        if (state_q == S_MUL) begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cyc_d    = cyc_q + CYW'(1);
            if (cyc_q == CYW'(WIDTH - 1)) begin
                stack_d[nidx] = prod[WIDTH-1:0];
                count_d = count_q - CW'(1);
                out_d   = prod[WIDTH-1:0];
                ovf_d   = ~(&prod[PW-1:WIDTH-1] | ~|prod[PW-1:WIDTH-1]);
                inv_d   = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end else if (opcode != OP_NOP) begin
            done_d = 1'b1;
            ovf_d  = 1'b0;
            inv_d  = 1'b0;
            unique case (opcode)
                OP_PUSH: if (room) begin
                    stack_d[pidx] = input_data;
                    count_d = count_q + CW'(1);
                    out_d   = input_data;
                end else inv_d = 1'b1;
                OP_POP: if (has1) begin
                    count_d = count_q - CW'(1);
                    out_d   = t_val;
                end else inv_d = 1'b1;
                OP_DUP: if (has1 && room) begin
                    stack_d[pidx] = t_val;
                    count_d = count_q + CW'(1);
                    out_d   = t_val;
                end else inv_d = 1'b1;
                OP_SWAP: if (has2) begin
                    stack_d[tidx] = n_val;
                    stack_d[nidx] = t_val;
                    out_d = n_val;
                end else inv_d = 1'b1;
                OP_ADD, OP_SUB: if (has2) begin
                    stack_d[nidx] = (opcode == OP_ADD) ? sum[WIDTH-1:0] : dif[WIDTH-1:0];
                    count_d = count_q - CW'(1);
                    out_d   = stack_d[nidx];
                    ovf_d   = (opcode == OP_ADD) ? (sum[WIDTH] ^ sum[WIDTH-1])
                                                 : (dif[WIDTH] ^ dif[WIDTH-1]);
                end else inv_d = 1'b1;
                OP_MUL: if (has2) begin
                    // Flags and result hold until the multiply completes.
                    done_d   = 1'b0;
                    ovf_d    = ovf_q;
                    inv_d    = inv_q;
                    state_d  = S_MUL;
                    mcand_d  = {{WIDTH{1'b0}}, mag_n};
                    mplier_d = mag_t;
                    acc_d    = '0;
                    neg_d    = n_val[WIDTH-1] ^ t_val[WIDTH-1];
                    cyc_d    = '0;
                end else inv_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
            count_q  <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
            done_q   <= 1'b0;
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cyc_q    <= '0;
        end else begin
            stack_q  <= stack_d;
            count_q  <= count_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
            done_q   <= done_d;
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cyc_q    <= cyc_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign op_done     = done_q;
    assign output_data = out_q;
    assign overflow    = ovf_q;
    assign invalid     = inv_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_stack_alu_param.sv
// Directed-vector bench for stack_alu_param (WIDTH=32, DEPTH=8).
module tb_stack_alu_param;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] SUB  = 3'b001;
    localparam logic [2:0] SWAP = 3'b010;
    localparam logic [2:0] DUP  = 3'b011;
    localparam logic [2:0] ADD  = 3'b100;
    localparam logic [2:0] MUL  = 3'b101;
    localparam logic [2:0] PUSH = 3'b110;
    localparam logic [2:0] POP  = 3'b111;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic signed [WIDTH-1:0] input_data = '0;
    logic        [2:0]       opcode = NOP;
    logic                    ready, op_done, overflow, invalid, empty, full;
    logic signed [WIDTH-1:0] output_data;
    logic        [CW-1:0]    count;

    int n_vec = 0;
    int n_err = 0;
    int lowcnt;

    stack_alu_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .input_data(input_data),
        .opcode(opcode), .ready(ready), .op_done(op_done),
        .output_data(output_data), .overflow(overflow),
        .invalid(invalid), .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic signed [WIDTH-1:0] d);
        @(negedge clk);
        opcode = op;
        input_data = d;
        @(posedge clk);
        #1;
        opcode = NOP;
    endtask

    // Result, count and flags after a single-cycle op.
    task automatic post(input string tag, input logic signed [63:0] o,
                        input int c, input logic ov, input logic iv);
        chk({tag, ".done"}, op_done, 1);
        chk({tag, ".out"}, output_data, o);
        chk({tag, ".cnt"}, count, c);
        chk({tag, ".ovf"}, overflow, ov);
        chk({tag, ".inv"}, invalid, iv);
    endtask

    task automatic wait_mul();
        lowcnt = 0;
        while (!ready && lowcnt < 100) begin
            opcode = (lowcnt == 5) ? PUSH : NOP;
            input_data = 77;
            @(posedge clk);
            #1;
            lowcnt++;
        end
        opcode = NOP;
    endtask

    initial begin
        #1;
        chk("rst.cnt", count, 0);
        chk("rst.out", output_data, 0);
        chk("rst.ready", ready, 1);
        chk("rst.done", op_done, 0);
        chk("rst.empty", empty, 1);
        chk("rst.full", full, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(PUSH, 10);     post("push10", 10, 1, 0, 0);
        issue(PUSH, 22);     post("push22", 22, 2, 0, 0);
        issue(ADD, 0);       post("add", 32, 1, 0, 0);
        @(posedge clk); #1;
        chk("add.pulse", op_done, 0);
        issue(POP, 0);       post("pop32", 32, 0, 0, 0);

        issue(PUSH, 2000000000);
        issue(PUSH, 2000000000);
        issue(ADD, 0);       post("addovf", -294967296, 1, 1, 0);
        issue(POP, 0);       post("popovf", -294967296, 0, 0, 0);

        issue(POP, 0);       post("popempty", -294967296, 0, 0, 1);
        chk("popempty.empty", empty, 1);
        issue(PUSH, 7);      post("push7", 7, 1, 0, 0);
        issue(ADD, 0);       post("add1", 7, 1, 0, 1);
        issue(MUL, 0);       post("mul1", 7, 1, 0, 1);
        chk("mul1.ready", ready, 1);
        issue(POP, 0);       post("pop7", 7, 0, 0, 0);

        issue(PUSH, -3);
        issue(PUSH, -5);
        issue(MUL, 0);
        chk("mul.readylow", ready, 0);
        chk("mul.nodone", op_done, 0);
        wait_mul();
        chk("mul.lowcycles", lowcnt, 32);
        post("mul", 15, 1, 0, 0);
        issue(POP, 0);       post("popmul", 15, 0, 0, 0);

        issue(PUSH, 2000000);
        issue(PUSH, -1000000);
        issue(MUL, 0);
        wait_mul();
        post("mulovf", 1454759936, 1, 1, 0);
        for (int i = 1; i <= 7; i++) issue(PUSH, i);
        chk("fill.full", full, 1);
        chk("fill.cnt", count, 8);
        issue(PUSH, 99);     post("pushfull", 7, 8, 0, 1);
        issue(POP, 0);       post("pop7b", 7, 7, 0, 0);
        issue(SWAP, 0);      post("swap", 5, 7, 0, 0);
        issue(DUP, 0);       post("dup", 5, 8, 0, 0);
        issue(DUP, 0);       post("dupfull", 5, 8, 0, 1);
        issue(POP, 0);       post("popa", 5, 7, 0, 0);
        issue(POP, 0);       post("popb", 5, 6, 0, 0);
        issue(POP, 0);       post("popc", 6, 5, 0, 0);
        issue(SUB, 0);       post("sub", -1, 4, 0, 0);

        issue(MUL, 0);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.cnt", count, 0);
        chk("arst.ready", ready, 1);
        chk("arst.out", output_data, 0);
        chk("arst.ovf", overflow, 0);
        chk("arst.inv", invalid, 0);
        chk("arst.done", op_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(PUSH, 42);     post("push42", 42, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stack_alu_param.md
Name: stack_alu_param

Overview:
Parametrised successor to the team's fixed-width stack ALU. It is a signed integer stack machine with configurable data width and stack depth. It adds SUB, DUP and SWAP opcodes, exposes stack occupancy flags, and uses an iterative multiplier with a ready/done handshake. It sits behind the opcode/data front end and drives result plus status flags to the host logic.

Parameters:
- WIDTH, 32, data width in bits; all operands and results are signed two's complement.
- DEPTH, 8, number of stack entries (>=2).
- CW, $clog2(DEPTH+1), width of the occupancy counter (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- input_data  in  WIDTH  signed operand for PUSH.
- opcode  in  3  operation, sampled only when ready=1.
- ready  out  1  block can accept a new opcode this cycle.
- op_done  out  1  one-cycle pulse when an accepted op completes.
- output_data  out  WIDTH  signed result of the last completed op.
- overflow  out  1  last completed arithmetic op overflowed WIDTH.
- invalid  out  1  last completed op was illegal for the stack state.
- count  out  CW  current number of stack entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (async, rst_n=0): count=0, output_data=0, overflow=0, invalid=0, op_done=0, ready=1, FSM=IDLE. Stack RAM contents are don't-care. Reset mid-multiply aborts the multiply with no stack update.
- Opcodes: 000 NOP, 001 SUB, 010 SWAP, 011 DUP, 100 ADD, 101 MUL, 110 PUSH, 111 POP.
- Accept rule: an op is accepted on a rising edge with ready=1 and opcode!=000. Opcodes presented while ready=0 are dropped, not queued. NOP never changes state or flags.
- Operand naming: T = top entry, N = entry below it.
- Single-cycle ops complete on the accepting edge. op_done pulses for the following cycle. output_data, overflow and invalid update on that same edge and hold until the next completion.
  - PUSH: needs count<DEPTH. T'=input_data, count+1, output_data=input_data.
  - POP: needs count>=1. output_data=T, count-1.
  - DUP: needs 1<=count<DEPTH. Pushes a copy of T, output_data=T.
  - SWAP: needs count>=2. Exchanges T and N, output_data = new T (old N).
  - ADD/SUB: need count>=2. Both T and N are removed and the result R=N+T or N-T is pushed, so count-1 and output_data=R. R is the low WIDTH bits. overflow=1 when the signed result is outside the WIDTH range.
- MUL: needs count>=2. FSM goes IDLE->MUL on the accepting edge and ready drops the next cycle.
  - Operand handling: operand magnitudes are latched and the multiplier runs radix-2 shift-add for WIDTH cycles, then the sign is applied.
  - Completion: on edge WIDTH after acceptance, N and T are replaced by the low WIDTH bits of N*T, count-1, output_data=product. overflow=1 if the 2*WIDTH product is not representable in WIDTH. FSM returns to IDLE and ready=1, op_done pulses.
  - Total latency: WIDTH+1 cycles from accept to op_done.
- Illegal op (precondition fails): stack and count are unchanged, invalid=1, overflow=0, output_data holds its previous value, op_done still pulses. MUL with count<2 completes in a single cycle as invalid and never enters MUL.
- Flags: invalid and overflow are cleared by the next legal completed op. overflow is always 0 for PUSH/POP/DUP/SWAP.
- Derived outputs: empty and full are combinational from count. A PUSH at full or a POP at empty leaves count saturated.

Test Plan:
- Basic add: reset, PUSH 10, PUSH 22, ADD -> output_data=32, count=1, overflow=0, invalid=0, one op_done pulse per op.
- Add overflow: PUSH 2000000000 twice, ADD -> output_data=-294967296, overflow=1, count decreases by 1. A following POP -> output_data=-294967296, overflow=0.
- Underflow: from empty, POP -> invalid=1, count=0, output_data unchanged. ADD with count=1 -> invalid=1, count stays 1.
- Multiply: PUSH -3, PUSH -5, MUL.
  - ready is low for 32 cycles, output_data=15, overflow=0.
  - A PUSH presented while ready=0 is ignored (count unchanged).
- Multiply overflow and depth limit:
  - PUSH 2000000, PUSH -1000000, MUL -> output_data=1454759936, overflow=1.
  - Then fill the stack to DEPTH=8 -> full=1. A further PUSH -> invalid=1, count=8.
  - DUP and SWAP checked against expected top values.
- Reset mid-op: assert rst_n=0 asynchronously 10 cycles into a MUL -> immediately count=0, ready=1, output_data=0, all flags 0. After release the block accepts PUSH normally.
